// File: rtl/rv64_fde_pkg.sv
// rv64_fde_pkg: opcodes, ALU/branch/operand-select enums and small decode helpers
// shared by the RV64I fetch/decode/execute block.
package rv64_fde_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
   localparam logic [6:0] OPC_STORE     = 7'h23;
   localparam logic [6:0] OPC_OP        = 7'h33;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_OP_32     = 7'h3b;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_JAL       = 7'h6f;
   localparam logic [6:0] OPC_SYSTEM    = 7'h73;

   localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
   localparam logic [31:0] INSN_MRET  = 32'h3020_0073;
   localparam logic [31:0] INSN_DONE  = 32'h0010_0073;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef enum logic [3:0] {
      BR_NONE, BR_JAL, BR_JALR, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
   } br_e;

   typedef enum logic [1:0] {A_SRC1, A_PC, A_ZERO} a_src_e;
   typedef enum logic [1:0] {B_SRC2, B_IMM, B_FOUR, B_CSR} b_src_e;

   // alt selects SUB/SRA; callers mask it where funct7 bit 5 is immediate data
   function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? ALU_SUB : ALU_ADD;
         3'd1: return ALU_SLL;
         3'd2: return ALU_SLT;
         3'd3: return ALU_SLTU;
         3'd4: return ALU_XOR;
         3'd5: return alt ? ALU_SRA : ALU_SRL;
         3'd6: return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic br_e br_of(input logic [2:0] f3);
      case (f3)
         3'd0: return BR_EQ;
         3'd1: return BR_NE;
         3'd4: return BR_LT;
         3'd5: return BR_GE;
         3'd6: return BR_LTU;
         3'd7: return BR_GEU;
         default: return BR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/rv64_fde_alu.sv
// rv64_fde_alu: combinational RV64I ALU; word ops (FDE_WORD_OPS_EN) compute on
// 32 bits and sign-extend bit 31.
module rv64_fde_alu
   import rv64_fde_pkg::*;
(
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  alu_op_e     op_i,
   input  logic        word_i,
   output logic [63:0] result_o
);

   logic [5:0]  sh;
   logic [63:0] r;

   assign sh = {b_i[5] & ~word_i, b_i[4:0]};

   always_comb begin
      case (op_i)
         ALU_SUB:  r = a_i - b_i;
         ALU_SLL:  r = a_i << sh;
         ALU_SLT:  r = {63'd0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: r = {63'd0, a_i < b_i};
         ALU_XOR:  r = a_i ^ b_i;
         ALU_SRL:  r = a_i >> sh;
         ALU_SRA:  r = $unsigned($signed(a_i) >>> sh);
         ALU_OR:   r = a_i | b_i;
         ALU_AND:  r = a_i & b_i;
         default:  r = a_i + b_i;
      endcase
   end

`ifdef FDE_WORD_OPS_EN
   logic [31:0] w;

   // add/sub/sll low halves match the 64-bit result; right shifts must see only 32 bits
   always_comb begin
      w = op_i == ALU_SRL ? a_i[31:0] >> sh[4:0] :
          op_i == ALU_SRA ? $unsigned($signed(a_i[31:0]) >>> sh[4:0]) : r[31:0];
   end

   assign result_o = word_i ? {{32{w[31]}}, w} : r;
`else
   assign result_o = r;
`endif

endmodule

// File: rtl/rv64_fetch_decode_execute.sv
// rv64_fetch_decode_execute: single-cycle RV64I PC register, decoder and ALU/branch unit.
// Define FDE_WORD_OPS_EN to decode OP-32/OP-IMM-32; otherwise they are illegal.
module rv64_fetch_decode_execute
   import rv64_fde_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic [63:0] csr_rdata,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] pc,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [63:0] imm,
   output logic        reg_wr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        mem_to_reg,
   output logic [2:0]  mem_op,
   output logic [63:0] alu_result,
   output logic        csr,
   output logic [11:0] csr_addr,
   output logic        ecall,
   output logic        mret,
   output logic        done,
   output logic        error
);

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [63:0] opa, opb, target, pc_q, pc_d;
   logic        r_ok, sh_ok, w_f3, wr, ld, st, ill, word, take;
   a_src_e      a_sel;
   b_src_e      b_sel;
   alu_op_e     alu_op;
   br_e         br;

   assign opc      = instr[6:0];
   assign f3       = instr[14:12];
   assign f7       = instr[31:25];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign rd       = instr[11:7];
   assign mem_op   = f3;
   assign csr_addr = instr[31:20];

   assign i_imm = {{52{instr[31]}}, instr[31:20]};
   assign s_imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign b_imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm = {{32{instr[31]}}, instr[31:12], 12'd0};
   assign j_imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // funct7 legality for register forms; shift-immediate legality for OP-IMM
   assign r_ok  = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
   assign sh_ok = f3 == 3'd1 ? instr[31:26] == 6'h00 :
                  f3 == 3'd5 ? (instr[31:26] == 6'h00 || instr[31:26] == 6'h10) : 1'b1;
   assign w_f3  = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5;

   always_comb begin
      imm    = i_imm;
      a_sel  = A_SRC1;
      b_sel  = B_IMM;
      alu_op = ALU_ADD;
      word   = 1'b0;
      br     = BR_NONE;
      wr     = 1'b0;
      ld     = 1'b0;
      st     = 1'b0;
      csr    = 1'b0;
      ecall  = 1'b0;
      mret   = 1'b0;
      done   = 1'b0;
      ill    = 1'b0;
      case (opc)
         OPC_LUI:    begin imm = u_imm; a_sel = A_ZERO; wr = 1'b1; end
         OPC_AUIPC:  begin imm = u_imm; a_sel = A_PC; wr = 1'b1; end
         OPC_JAL:    begin imm = j_imm; a_sel = A_PC; b_sel = B_FOUR; br = BR_JAL; wr = 1'b1; end
         OPC_JALR:   begin a_sel = A_PC; b_sel = B_FOUR; br = BR_JALR; wr = 1'b1; ill = f3 != 3'd0; end
         OPC_BRANCH: begin imm = b_imm; br = br_of(f3); ill = f3[2:1] == 2'b01; end
         OPC_LOAD:   begin ld = 1'b1; wr = 1'b1; ill = f3 == 3'd7; end
         OPC_STORE:  begin imm = s_imm; st = 1'b1; ill = f3[2]; end
         OPC_OP_IMM: begin alu_op = alu_of(f3, instr[30] & f3 == 3'd5); wr = 1'b1; ill = !sh_ok; end
         OPC_OP:     begin b_sel = B_SRC2; alu_op = alu_of(f3, instr[30]); wr = 1'b1; ill = !r_ok; end
`ifdef FDE_WORD_OPS_EN
         OPC_OP_IMM_32: begin
            alu_op = alu_of(f3, instr[30] & f3 == 3'd5);
            word   = 1'b1;
            wr     = 1'b1;
            ill    = !(f3 == 3'd0 || ((f3 == 3'd1 || f3 == 3'd5) && r_ok));
         end
         OPC_OP_32: begin
            b_sel  = B_SRC2;
            alu_op = alu_of(f3, instr[30]);
            word   = 1'b1;
            wr     = 1'b1;
            ill    = !(w_f3 && r_ok);
         end
`endif
         OPC_SYSTEM: begin
            if (f3 == 3'd0) begin
               ecall = instr == INSN_ECALL;
               mret  = instr == INSN_MRET;
               done  = instr == INSN_DONE;
               ill   = !(instr == INSN_ECALL || instr == INSN_MRET || instr == INSN_DONE);
            end else begin
               a_sel = A_ZERO;
               b_sel = B_CSR;
               csr   = f3 != 3'd4;
               wr    = 1'b1;
               ill   = f3 == 3'd4;
            end
         end
         default: ill = 1'b1;
      endcase
   end

   assign error      = ill;
   assign reg_wr     = wr & ~ill;
   assign mem_rd     = ld & ~ill;
   assign mem_to_reg = ld & ~ill;
   assign mem_wr     = st & ~ill;

   assign opa = a_sel == A_PC ? pc_q : a_sel == A_ZERO ? 64'd0 : src1;
   assign opb = b_sel == B_SRC2 ? src2 : b_sel == B_FOUR ? 64'd4 :
                b_sel == B_CSR ? csr_rdata : imm;

   rv64_fde_alu u_alu (
      .a_i      (opa),
      .b_i      (opb),
      .op_i     (alu_op),
      .word_i   (word & ~w_f3 | word),
      .result_o (alu_result)
   );

   always_comb begin
      case (br)
         BR_JAL, BR_JALR: take = 1'b1;
         BR_EQ:  take = src1 == src2;
         BR_NE:  take = src1 != src2;
         BR_LT:  take = $signed(src1) < $signed(src2);
         BR_GE:  take = $signed(src1) >= $signed(src2);
         BR_LTU: take = src1 < src2;
         BR_GEU: take = src1 >= src2;
         default: take = 1'b0;
      endcase
   end

   assign target = br == BR_JALR ? (src1 + imm) & ~64'h1 : pc_q + imm;
   assign pc_d   = redirect ? redirect_pc : (take & ~ill) ? target : pc_q + 64'd4;
   assign pc     = pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= RESET_PC;
      else pc_q <= pc_d;
   end

endmodule

// File: tb/tb_rv64_fetch_decode_execute.sv
// tb_rv64_fetch_decode_execute: directed scoreboard bench; expectations are queued as
// each instruction is driven and compared once decode settles or the PC edge occurs.
module tb_rv64_fetch_decode_execute;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = 32'h0000_0013;
   logic [63:0] src1 = '0, src2 = '0, csr_rdata = '0, redirect_pc = '0;
   logic        redirect = 1'b0;
   logic [63:0] pc, imm, alu_result;
   logic [4:0]  rs1, rs2, rd;
   logic        reg_wr, mem_rd, mem_wr, mem_to_reg, csr, ecall, mret, done, error;
   logic [2:0]  mem_op;
   logic [11:0] csr_addr;

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   rv64_fetch_decode_execute #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .instr(instr), .src1(src1), .src2(src2),
      .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .pc(pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
      .mem_op(mem_op), .alu_result(alu_result), .csr(csr), .csr_addr(csr_addr),
      .ecall(ecall), .mret(mret), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] observe(input string t);
      case (t)
         "pc":         return pc;
         "rs1":        return 64'(rs1);
         "rd":         return 64'(rd);
         "imm":        return imm;
         "alu":        return alu_result;
         "reg_wr":     return 64'(reg_wr);
         "mem_rd":     return 64'(mem_rd);
         "mem_wr":     return 64'(mem_wr);
         "mem_to_reg": return 64'(mem_to_reg);
         "mem_op":     return 64'(mem_op);
         "csr":        return 64'(csr);
         "csr_addr":   return 64'(csr_addr);
         "ecall":      return 64'(ecall);
         "mret":       return 64'(mret);
         "done":       return 64'(done);
         "error":      return 64'(error);
         default:      return 'x;
      endcase
   endfunction

   task automatic ex(input string t, input logic [63:0] e);
      sb.push_back('{t, e});
   endtask

   task automatic drain();
      exp_t        e;
      logic [63:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.tag);
         vectors++;
         assert (o === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic apply(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      instr = i;
      src1  = a;
      src2  = b;
   endtask

   // compare decode outputs now, then the PC after the next rising edge
   task automatic settle(input logic [63:0] npc);
      #1 drain();
      ex("pc", npc);
      @(posedge clk);
      #1 drain();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 ex("pc", RST_PC);
      drain();

      apply(32'h0050_0093, 64'd0, 64'd0);
      rst = 1'b1;
      ex("rd", 1); ex("reg_wr", 1); ex("alu", 5); ex("error", 0);
      settle(64'h8000_0004);

      apply(32'h0020_8463, 64'd7, 64'd7);
      ex("imm", 8); ex("reg_wr", 0);
      settle(64'h8000_000c);

      apply(32'h0020_8463, 64'd7, 64'd8);
      settle(64'h8000_0010);

      apply(32'h0000_80e7, 64'h8000_0101, 64'd0);
      ex("alu", 64'h8000_0014); ex("reg_wr", 1);
      settle(64'h8000_0100);

      apply(32'h0081_3183, 64'h1000, 64'd0);
      ex("rs1", 2); ex("rd", 3); ex("mem_rd", 1); ex("mem_to_reg", 1);
      ex("mem_op", 3); ex("alu", 64'h1008); ex("mem_wr", 0); ex("reg_wr", 1);
      settle(64'h8000_0104);

      apply(32'h4020_8133, 64'd5, 64'd7);
      ex("alu", 64'hffff_ffff_ffff_fffe);
      settle(64'h8000_0108);

      apply(32'h4040_d093, 64'h8000_0000_0000_0000, 64'd0);
      ex("alu", 64'hf800_0000_0000_0000);
      settle(64'h8000_010c);

      apply(32'h0020_b0b3, 64'd1, 64'hffff_ffff_ffff_ffff);
      ex("alu", 1);
      settle(64'h8000_0110);

      apply(32'h0020_a0b3, 64'd1, 64'hffff_ffff_ffff_ffff);
      ex("alu", 0);
      settle(64'h8000_0114);

      apply(32'h0020_80bb, 64'h7fff_ffff, 64'd1);
`ifdef FDE_WORD_OPS_EN
      ex("alu", 64'hffff_ffff_8000_0000); ex("error", 0); ex("reg_wr", 1);
`else
      ex("error", 1); ex("reg_wr", 0);
`endif
      settle(64'h8000_0118);

      apply(32'h0010_0073, 64'd0, 64'd0);
      ex("done", 1); ex("ecall", 0); ex("error", 0); ex("reg_wr", 0);
      settle(64'h8000_011c);

      apply(32'h0000_0073, 64'd0, 64'd0);
      ex("ecall", 1); ex("done", 0);
      settle(64'h8000_0120);

      apply(32'h3020_0073, 64'd0, 64'd0);
      ex("mret", 1); ex("ecall", 0);
      settle(64'h8000_0124);

      apply(32'h3001_10f3, 64'd0, 64'd0);
      csr_rdata = 64'h1234;
      ex("csr", 1); ex("csr_addr", 12'h300); ex("alu", 64'h1234); ex("reg_wr", 1); ex("error", 0);
      settle(64'h8000_0128);

      apply(32'hffff_ffff, 64'd0, 64'd0);
      ex("error", 1); ex("reg_wr", 0); ex("mem_wr", 0); ex("mem_rd", 0);
      settle(64'h8000_012c);

      apply(32'h0020_8463, 64'd5, 64'd5);
      redirect    = 1'b1;
      redirect_pc = 64'h8000_1000;
      settle(64'h8000_1000);
      redirect = 1'b0;

      apply(32'h0080_00ef, 64'd0, 64'd0);
      ex("alu", 64'h8000_1004); ex("rd", 1); ex("reg_wr", 1);
      settle(64'h8000_1008);

      apply(32'h0020_b823, 64'h2000, 64'd9);
      ex("imm", 16); ex("alu", 64'h2010); ex("mem_wr", 1); ex("reg_wr", 0); ex("mem_rd", 0);
      settle(64'h8000_100c);

      apply(32'h0000_0013, 64'd0, 64'd0);
      #2 rst = 1'b0;
      #1 ex("pc", RST_PC);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
